// File: rtl/neuron_pkg.sv
// Shared types and helpers for the sequential neuron datapath and later layer blocks.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2,
    OUT  = 2'd3
  } neuron_state_e;

  typedef enum logic [1:0] {
    ACT_RELU   = 2'b00,
    ACT_LINEAR = 2'b01,
    ACT_CLAMP  = 2'b10,
    ACT_RSVD   = 2'b11
  } act_mode_e;

  localparam int unsigned SAT_W = 64;

  // Clip a signed value to the two's-complement range of an out_w-bit word.
  function automatic logic signed [SAT_W-1:0] sat_to_width(
    input logic signed [SAT_W-1:0] val,
    input int unsigned             out_w
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (val > max_v) begin
      sat_to_width = max_v;
    end else if (val < min_v) begin
      sat_to_width = min_v;
    end else begin
      sat_to_width = val;
    end
  endfunction

endpackage

// File: rtl/nn_saturate.sv
// Combinational signed clip from IN_WIDTH to OUT_WIDTH with a flag raised when
// the value had to be changed.
module nn_saturate
  import neuron_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 19,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic signed [IN_WIDTH-1:0]  val_i,
  output logic signed [OUT_WIDTH-1:0] val_o,
  output logic                        sat_o
);

  logic signed [SAT_W-1:0] wide_s;
  logic signed [SAT_W-1:0] clip_s;

  // Widen, clip through the shared helper, and flag any change.
  always_comb begin
    wide_s = SAT_W'(val_i);
    clip_s = sat_to_width(wide_s, OUT_WIDTH);
    val_o  = clip_s[OUT_WIDTH-1:0];
    sat_o  = (clip_s != wide_s);
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Single neuron: N_INPUTS sequential MACs on one shared multiplier, full-precision
// accumulation, selectable activation and saturation, valid/ready on both sides.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int N_INPUTS   = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N_INPUTS+1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [1:0]                     act_mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] x_flat,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] w_flat,
  input  logic [DATA_WIDTH-1:0]          bias,
  output logic [DATA_WIDTH-1:0]          y,
  output logic                           sat,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] CLAMP_HI =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS-1);

  neuron_state_e                  state_q, state_d;
  act_mode_e                      mode_q, mode_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [N_INPUTS*DATA_WIDTH-1:0] x_q, x_d;
  logic [N_INPUTS*DATA_WIDTH-1:0] w_q, w_d;
  logic [DATA_WIDTH-1:0]          y_q, y_d;
  logic                           sat_q, sat_d;
  logic                           out_valid_q, out_valid_d;
  logic                           in_ready_q, in_ready_d;

  logic signed [DATA_WIDTH-1:0]   x_sel_s, w_sel_s;
  logic signed [PROD_W-1:0]       prod_s, prod_shr_s;
  logic signed [ACC_WIDTH-1:0]    act_s;
  logic signed [DATA_WIDTH-1:0]   sat_y_s;
  logic                           sat_flag_s;

  // Shared multiplier; the arithmetic shift truncates toward minus infinity.
  always_comb begin
    x_sel_s    = $signed(x_q[idx_q*DATA_WIDTH +: DATA_WIDTH]);
    w_sel_s    = $signed(w_q[idx_q*DATA_WIDTH +: DATA_WIDTH]);
    prod_s     = x_sel_s * w_sel_s;
    prod_shr_s = prod_s >>> FRAC_BITS;
  end

  // Activation on the full-precision accumulator ahead of the final clip.
  always_comb begin
    act_s = acc_q;
    case (mode_q)
      ACT_RELU: begin
        if (acc_q[ACC_WIDTH-1]) begin
          act_s = {ACC_WIDTH{1'b0}};
        end else begin
          act_s = acc_q;
        end
      end
      ACT_CLAMP: begin
        if (acc_q[ACC_WIDTH-1]) begin
          act_s = {ACC_WIDTH{1'b0}};
        end else if (acc_q > CLAMP_HI) begin
          act_s = CLAMP_HI;
        end else begin
          act_s = acc_q;
        end
      end
      ACT_LINEAR, ACT_RSVD: act_s = acc_q;
      default:              act_s = acc_q;
    endcase
  end

  nn_saturate #(
    .IN_WIDTH (ACC_WIDTH),
    .OUT_WIDTH(DATA_WIDTH)
  ) u_sat (
    .val_i(act_s),
    .val_o(sat_y_s),
    .sat_o(sat_flag_s)
  );

  // Next-state and datapath updates for the IDLE/MAC/ACT/OUT sequence.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    x_d         = x_q;
    w_d         = w_q;
    y_d         = y_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x_flat;
          w_d     = w_flat;
          mode_d  = act_mode_e'(act_mode);
          acc_d   = ACC_WIDTH'($signed(bias));
          idx_d   = {IDX_W{1'b0}};
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_WIDTH'(prod_shr_s);
        if (idx_q == IDX_LAST) begin
          state_d = ACT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ACT: begin
        y_d         = sat_y_s;
        sat_d       = sat_flag_s;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State register: synchronous reset wins, en=0 freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= ACT_RELU;
      idx_q       <= {IDX_W{1'b0}};
      acc_q       <= {ACC_WIDTH{1'b0}};
      x_q         <= {(N_INPUTS*DATA_WIDTH){1'b0}};
      w_q         <= {(N_INPUTS*DATA_WIDTH){1'b0}};
      y_q         <= {DATA_WIDTH{1'b0}};
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (en) begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      w_q         <= w_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign y         = y_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq with N_INPUTS = 4, 1 and 7 instances.
module tb_neuron_mac_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, out_ready;
  logic [1:0] act_mode;
  logic [7:0] bias;

  logic        in_valid4, in_ready4, out_valid4, sat4;
  logic [31:0] x4, w4;
  logic [7:0]  y4;

  logic        in_valid1, in_ready1, out_valid1, sat1;
  logic [7:0]  x1, w1, y1;

  logic        in_valid7, in_ready7, out_valid7, sat7;
  logic [55:0] x7, w7;
  logic [7:0]  y7;

  int ncmp  = 0;
  int nfail = 0;
  int lat;

  neuron_mac_seq #(.DATA_WIDTH(8), .FRAC_BITS(4), .N_INPUTS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .act_mode(act_mode),
    .in_valid(in_valid4), .in_ready(in_ready4), .x_flat(x4), .w_flat(w4),
    .bias(bias), .y(y4), .sat(sat4), .out_valid(out_valid4), .out_ready(out_ready)
  );

  neuron_mac_seq #(.DATA_WIDTH(8), .FRAC_BITS(4), .N_INPUTS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .act_mode(act_mode),
    .in_valid(in_valid1), .in_ready(in_ready1), .x_flat(x1), .w_flat(w1),
    .bias(bias), .y(y1), .sat(sat1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  neuron_mac_seq #(.DATA_WIDTH(8), .FRAC_BITS(4), .N_INPUTS(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .en(en), .act_mode(act_mode),
    .in_valid(in_valid7), .in_ready(in_ready7), .x_flat(x7), .w_flat(w7),
    .bias(bias), .y(y7), .sat(sat7), .out_valid(out_valid7), .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake one vector into dut4 and count edges until out_valid rises.
  task automatic run4(input logic [31:0] xv, input logic [31:0] wv,
                      input logic [7:0] bv, input logic [1:0] mode, output int l);
    x4 = xv; w4 = wv; bias = bv; act_mode = mode;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    l = 0;
    while (out_valid4 !== 1'b1 && l < 64) begin
      tick();
      l++;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b1; act_mode = 2'b00; bias = 8'h00;
    in_valid4 = 1'b0; x4 = 32'h0; w4 = 32'h0;
    in_valid1 = 1'b0; x1 = 8'h0;  w1 = 8'h0;
    in_valid7 = 1'b0; x7 = 56'h0; w7 = 56'h0;
    tick();
    tick();
    check("rst_y",         32'(y4),         32'h0);
    check("rst_sat",       32'(sat4),       32'h0);
    check("rst_out_valid", 32'(out_valid4), 32'h0);
    check("rst_in_ready",  32'(in_ready4),  32'h1);
    check("rst_y1",        32'(y1),         32'h0);
    check("rst_y7",        32'(y7),         32'h0);
    rst_n = 1'b1;
    tick();

    // W=(8,5,-17,-5), bias 6, X=1.0 each: acc=-3
    check("c1_in_ready", 32'(in_ready4), 32'h1);
    run4(32'h10101010, 32'hFBEF0508, 8'h06, 2'b00, lat);
    check("c1_relu_lat", 32'(lat),  32'd5);
    check("c1_relu_y",   32'(y4),   32'h00);
    check("c1_relu_sat", 32'(sat4), 32'h0);
    tick();
    check("c1_ov_drop",  32'(out_valid4), 32'h0);
    check("c1_ir_back",  32'(in_ready4),  32'h1);
    run4(32'h10101010, 32'hFBEF0508, 8'h06, 2'b01, lat);
    check("c1_lin_y",    32'(y4),   32'hFD);
    check("c1_lin_sat",  32'(sat4), 32'h0);
    tick();

    // X=(2.0,0,0,0): acc=22
    run4(32'h00000020, 32'hFBEF0508, 8'h06, 2'b00, lat);
    check("c2_relu_y",   32'(y4),   32'h16);
    check("c2_relu_lat", 32'(lat),  32'd5);
    tick();
    run4(32'h00000020, 32'hFBEF0508, 8'h06, 2'b10, lat);
    check("c2_clamp_y",   32'(y4),   32'h10);
    check("c2_clamp_sat", 32'(sat4), 32'h0);
    check("c2_clamp_lat", 32'(lat),  32'd5);
    tick();

    // Saturation: acc=4032 and acc=-4064
    run4(32'h7F7F7F7F, 32'h7F7F7F7F, 8'h00, 2'b01, lat);
    check("satp_y",   32'(y4),   32'h7F);
    check("satp_sat", 32'(sat4), 32'h1);
    tick();
    run4(32'h7F7F7F7F, 32'h80808080, 8'h00, 2'b01, lat);
    check("satn_y",   32'(y4),   32'h80);
    check("satn_sat", 32'(sat4), 32'h1);
    tick();

    // Backpressure: result held, new in_valid ignored
    out_ready = 1'b0;
    run4(32'h00000020, 32'hFBEF0508, 8'h06, 2'b00, lat);
    check("bp_lat", 32'(lat), 32'd5);
    x4 = 32'h7F7F7F7F;
    in_valid4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_ov",  32'(out_valid4), 32'h1);
      check("bp_y",   32'(y4),         32'h16);
      check("bp_sat", 32'(sat4),       32'h0);
      check("bp_ir",  32'(in_ready4),  32'h0);
    end
    in_valid4 = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_ov_drop", 32'(out_valid4), 32'h0);
    check("bp_ir_back", 32'(in_ready4),  32'h1);
    check("bp_y_keep",  32'(y4),         32'h16);

    // Reset during MAC at idx=2
    x4 = 32'h10101010; w4 = 32'hFBEF0508; bias = 8'h06; act_mode = 2'b01;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_ov", 32'(out_valid4), 32'h0);
    check("mrst_y",  32'(y4),         32'h0);
    check("mrst_ir", 32'(in_ready4),  32'h1);
    run4(32'h7F7F7F7F, 32'h7F7F7F7F, 8'h00, 2'b01, lat);
    check("mrst_lat", 32'(lat),  32'd5);
    check("mrst_y2",  32'(y4),   32'h7F);
    check("mrst_sat", 32'(sat4), 32'h1);
    tick();

    // en low for three edges mid-MAC
    x4 = 32'h10101010; w4 = 32'hFBEF0508; bias = 8'h06; act_mode = 2'b01;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 64) begin
      en = (lat >= 2 && lat < 5) ? 1'b0 : 1'b1;
      tick();
      lat++;
    end
    en = 1'b1;
    check("en_lat", 32'(lat),  32'd8);
    check("en_y",   32'(y4),   32'hFD);
    check("en_sat", 32'(sat4), 32'h0);
    tick();

    // N_INPUTS=1 truncation: -1/16 * 1/16 rounds to -1 lsb
    x1 = 8'hFF; w1 = 8'h01; bias = 8'h00; act_mode = 2'b01;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    lat = 0;
    while (out_valid1 !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check("n1_lat", 32'(lat),  32'd2);
    check("n1_y",   32'(y1),   32'hFF);
    check("n1_sat", 32'(sat1), 32'h0);
    tick();

    // N_INPUTS=7: first case plus weights (1,-2,-1): acc=-5
    x7 = {7{8'h10}}; w7 = 56'hFFFE01FBEF0508; bias = 8'h06; act_mode = 2'b01;
    in_valid7 = 1'b1;
    tick();
    in_valid7 = 1'b0;
    lat = 0;
    while (out_valid7 !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check("n7_lat", 32'(lat),  32'd8);
    check("n7_y",   32'(y7),   32'hFB);
    check("n7_sat", 32'(sat7), 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
